// File: rtl/div_pkg.sv
// Shared encodings for the EX-stage divider: FSM states, handshake levels
// and the register bus widths used by EX when writing {Hi, Lo}.
package div_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 2 * REG_BUS;

    typedef enum logic [1:0] {
        DIV_FREE     = 2'b00,
        DIV_BY_ZERO  = 2'b01,
        DIV_ON       = 2'b10,
        DIV_END      = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for div/divu. One quotient bit per clock,
// result presented as {remainder, quotient} and held until EX drops start.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = REG_BUS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_t             state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [2*DATA_W-1:0]    result_n;
    logic                   ready_n;

    // Dividend is consumed MSB-first by shifting; quotient fills from the LSB.
    logic [DATA_W-1:0]      dividend, dividend_n;
    logic [DATA_W-1:0]      divisor, divisor_n;
    logic [DATA_W-1:0]      quo, quo_n;
    // After each step the partial remainder is below the divisor, so its
    // top bit is always zero and only DATA_W bits need to be kept.
    logic [DATA_W-1:0]      rem, rem_n;
    logic                   neg_quo, neg_quo_n;
    logic                   neg_rem, neg_rem_n;

    logic [DATA_W:0]        trial;
    logic                   ge;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return (~v) + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] abs_op(input logic [DATA_W-1:0] v,
                                                 input logic              sgn);
        return (sgn && v[DATA_W-1]) ? negate(v) : v;
    endfunction

    // Next-state, step datapath (shift/compare/subtract) and output values.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        result_n   = result_o;
        ready_n    = ready_o;
        dividend_n = dividend;
        divisor_n  = divisor;
        quo_n      = quo;
        rem_n      = rem;
        neg_quo_n  = neg_quo;
        neg_rem_n  = neg_rem;

        trial = {rem, dividend[DATA_W-1]};
        ge    = (trial >= {1'b0, divisor});

        case (state)
            DIV_FREE: begin
                ready_n  = DIV_RESULT_NOT_READY;
                result_n = '0;
                if (start_i == DIV_START && !annul_i) begin
                    state_n    = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                    cnt_n      = '0;
                    dividend_n = abs_op(opdata1_i, signed_div_i);
                    divisor_n  = abs_op(opdata2_i, signed_div_i);
                    neg_quo_n  = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                    neg_rem_n  = signed_div_i & opdata1_i[DATA_W-1];
                    rem_n      = '0;
                    quo_n      = '0;
                end
            end
            DIV_BY_ZERO: begin
                state_n  = DIV_END;
                result_n = '0;
                ready_n  = DIV_RESULT_READY;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_n  = DIV_FREE;
                    ready_n  = DIV_RESULT_NOT_READY;
                    result_n = '0;
                    cnt_n    = '0;
                end else if (cnt != CNT_LAST) begin
                    rem_n      = ge ? DATA_W'(trial - {1'b0, divisor}) : trial[DATA_W-1:0];
                    quo_n      = {quo[DATA_W-2:0], ge};
                    dividend_n = {dividend[DATA_W-2:0], 1'b0};
                    cnt_n      = cnt + CNT_W'(1);
                end else begin
                    result_n = {neg_rem ? negate(rem) : rem,
                                neg_quo ? negate(quo) : quo};
                    ready_n  = DIV_RESULT_READY;
                    state_n  = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP || annul_i) begin
                    state_n  = DIV_FREE;
                    ready_n  = DIV_RESULT_NOT_READY;
                    result_n = '0;
                end
            end
            default: begin
                state_n = DIV_FREE;
            end
        endcase
    end

    // Control and output registers; reset asynchronously from any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    // Operand and partial-result registers; always loaded before use.
    always_ff @(posedge clk) begin
        dividend <= dividend_n;
        divisor  <= divisor_n;
        quo      <= quo_n;
        rem      <= rem_n;
        neg_quo  <= neg_quo_n;
        neg_rem  <= neg_rem_n;
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the EX-stage divider: latency, signed/unsigned results,
// divide-by-zero, annul and asynchronous reset.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int vectors     = 0;
    int miscompares = 0;
    int edges;
    logic pulsed;

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Start an operation at a negedge, scramble operands after E0, and wait
    // (bounded) for ready. edges counts rising edges from E0 inclusive.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        n            = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                opdata1_i    = 32'h1234_5678;
                opdata2_i    = 32'h0;
                signed_div_i = ~sgn;
            end
            if (ready_o) break;
        end
    endtask

    task automatic stop_op();
        start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready",  64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // divu 100 / 7
        run_op(1'b0, 32'd100, 32'd7, edges);
        check("divu_100_7_latency", 64'(edges), 64'd34);
        check("divu_100_7_result", result_o, {32'h0000_0002, 32'h0000_000E});
        @(posedge clk);
        @(negedge clk);
        check("divu_100_7_hold_ready",  64'(ready_o), 64'd1);
        check("divu_100_7_hold_result", result_o, {32'h0000_0002, 32'h0000_000E});
        stop_op();
        check("divu_100_7_drop_ready",  64'(ready_o), 64'd0);
        check("divu_100_7_drop_result", result_o, 64'd0);

        // div -7 / 2 and divu of the same operands
        run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, edges);
        check("div_m7_2_latency", 64'(edges), 64'd34);
        check("div_m7_2_result", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        stop_op();
        run_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, edges);
        check("divu_fff9_2_result", result_o, {32'h0000_0001, 32'h7FFF_FFFC});
        stop_op();

        // Most-negative / -1, signed: no trap
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, edges);
        check("div_min_m1_result", result_o, {32'h0000_0000, 32'h8000_0000});
        stop_op();

        // divu 0xFFFFFFFF / 1, then async reset while the result is held
        run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, edges);
        check("divu_max_1_result", result_o, {32'h0000_0000, 32'hFFFF_FFFF});
        #2 rst = 1'b1;
        #1;
        check("rst_in_end_ready",  64'(ready_o), 64'd0);
        check("rst_in_end_result", result_o, 64'd0);
        start_i = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);

        // Divide by zero, both signedness
        run_op(1'b1, 32'd123, 32'd0, edges);
        check("div_by_zero_s_latency", 64'(edges), 64'd2);
        check("div_by_zero_s_result", result_o, 64'd0);
        stop_op();
        run_op(1'b0, 32'hFFFF_FFFF, 32'd0, edges);
        check("div_by_zero_u_latency", 64'(edges), 64'd2);
        check("div_by_zero_u_result", result_o, 64'd0);
        stop_op();

        // Annul at cnt=10, then a clean 9 / 3
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("annul_ready",  64'(ready_o), 64'd0);
        check("annul_result", result_o, 64'd0);
        annul_i = 1'b0;
        start_i = 1'b0;
        pulsed  = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (ready_o) pulsed = 1'b1;
        end
        check("annul_no_ready_pulse", 64'(pulsed), 64'd0);
        run_op(1'b0, 32'd9, 32'd3, edges);
        check("after_annul_latency", 64'(edges), 64'd34);
        check("after_annul_result", result_o, {32'h0, 32'h0000_0003});
        stop_op();

        // Async reset mid-DivOn, then divu 50 / 5
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1234;
        opdata2_i    = 32'd5;
        start_i      = 1'b1;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("rst_in_on_ready",  64'(ready_o), 64'd0);
        check("rst_in_on_result", result_o, 64'd0);
        start_i = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, 32'd50, 32'd5, edges);
        check("after_rst_latency", 64'(edges), 64'd34);
        check("after_rst_result", result_o, {32'h0, 32'h0000_000A});
        stop_op();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle 32-bit integer divider serving the EX stage for div/divu.
- EX drives start, operands and signedness, and holds its stall request until ready is seen.
- Divider returns {remainder, quotient} as one 64-bit word, which EX writes to {Hi, Lo}.
- Radix-2 restoring division, one quotient bit per clock; sits beside EX, clocked with the pipeline.

Parameters:
- DATA_W, 32, operand width. Result width is 2*DATA_W; iteration count equals DATA_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable).
- signed_div_i  in  1  1 = signed (div), 0 = unsigned (divu); sampled at start.
- opdata1_i  in  32  dividend; sampled at start.
- opdata2_i  in  32  divisor; sampled at start.
- start_i  in  1  `DivStart / `DivStop from EX; level, held high while EX stalls.
- annul_i  in  1  cancel the operation in flight (flush); has priority over start_i.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; registered.
- ready_o  out  1  `DivResultReady / `DivResultNotReady; registered.

Behaviour:
- Reset (asynchronous, any state): state=DivFree, cnt=0, result_o=0, ready_o=`DivResultNotReady.

States:
- DivFree
  - start_i=1, annul_i=0, opdata2_i=0: go to DivByZero.
  - start_i=1, annul_i=0, opdata2_i≠0: go to DivOn, cnt=0.
  - Latch operands at the transition:
    - signed_div_i=1: latch |op| of each operand (two's-complement negate if MSB=1), plus both sign bits.
    - signed_div_i=0: latch operands raw.
  - Partial remainder r (33 bits) cleared.
  - Otherwise stay in DivFree; ready_o=0, result_o=0.
- DivByZero
  - Next edge: go to DivEnd with result_o=0 and ready_o=1.
- DivOn
  - If annul_i=1: go to DivFree, ready_o=0, result_o=0, cnt=0.
  - Else if cnt<32, one step per edge:
    - r = {r[31:0], dividend bit [31-cnt]}.
    - If r ≥ {1'b0, divisor}: r -= divisor, quotient bit [31-cnt] = 1; else the bit is 0.
    - cnt++.
  - Else (cnt==32): finalize, go to DivEnd, ready_o=1.
    - Quotient is negated if signed and the operand signs differ.
    - Remainder is negated if signed and the dividend is negative.
    - result_o = {rem, quo}.
- DivEnd
  - Hold result_o and ready_o while start_i=1.
  - When start_i=0 or annul_i=1: go to DivFree, ready_o=0, result_o=0.

Latency and handshake:
- Let E0 be the edge where start is first sampled in DivFree.
- Steps occur at E1..E32; finalize at E33; ready_o is high after E33. That is 34 cycles of stall.
- Divide-by-zero: ready_o is high after E1.
- Result stays valid until start_i drops. EX drops start in the cycle it sees ready, so exactly one cycle of ready is consumed.

Boundary conditions:
- Operand changes after E0 are ignored.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. No trap.
- Divide-by-zero result is 0 (architecturally UNPREDICTABLE; fixed here for determinism).
- start_i and annul_i both high in DivFree: no start.
- Unsigned 33-bit compare only; no sign handling inside the loop.

Decomposition:
- Shared defines file holds:
  - State encodings: `DivFree 2'b00, `DivByZero 2'b01, `DivOn 2'b10, `DivEnd 2'b11.
  - Handshake values: `DivResultReady 1'b1, `DivResultNotReady 1'b0, `DivStart 1'b1, `DivStop 1'b0.
  - Bus widths `RegBus and `DoubleRegBus.
- Single module; a separate sub-module is not warranted. The step logic (compare, subtract, shift) stays inline as one combinational always block feeding the state register.

Test Plan:
- divu 100 / 7, start held: ready_o rises after exactly 34 edges from E0; result_o = {0x00000002, 0x0000000E}; start drop → ready_o=0 and result_o=0 next edge.
- div −7 / 2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Also divu of the same operands gives quotient 0x7FFFFFFC and remainder 1.
- div 0x80000000 / 0xFFFFFFFF, signed: result_o = {0x00000000, 0x80000000}. Also divu 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
- Divide by zero, any signedness: ready_o high after 2 edges; result_o = 0.
- Annul asserted at cnt=10 → DivFree next edge, ready_o never pulses. A following start of 9/3 completes in the full 34 cycles with {0, 3}.
- Async rst pulsed mid-DivOn, between clock edges: ready_o=0 and result_o=0 immediately; a new divu 50/5 afterwards gives {0, 10}.
